// File: rtl/mult_div_sequencer.sv
// Sequencer for the shared multiplier/divider: issues the op pulse, waits out the unit latency,
// writes HI/LOW and signals done. Define MULTDIV_ABORT_EN to add the abort port.
//
// state | meaning
// IDLE  | waiting for start_mult / start_div
// RUN   | op pulsed in first cycle, counting down unit latency
// WB    | hi_lo_write asserted for one cycle
// DONE  | done asserted for one cycle
// EXC   | div_zero_exc asserted for one cycle (div aborted by divide-by-zero)
module mult_div_sequencer #(
    parameter int MULT_LAT = 33,
    parameter int DIV_LAT  = 33,
    parameter int CNT_W    = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    input  logic div_by_zero,
`ifdef MULTDIV_ABORT_EN
    input  logic abort,
`endif
    output logic mult_op,
    output logic div_op,
    output logic mult_div_sel,
    output logic hi_lo_write,
    output logic busy,
    output logic done,
    output logic div_zero_exc
);

    typedef enum logic [2:0] {IDLE, RUN, WB, DONE, EXC} seqStateT;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    seqStateT         state, nextState;
    logic [CNT_W-1:0] latCnt;
    logic             opIsDiv;
    logic             firstRun;
    logic             startAny;
    logic             abortHit;

    assign startAny = start_mult | start_div;

`ifdef MULTDIV_ABORT_EN
    assign abortHit = abort;
`else
    assign abortHit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            latCnt   <= '0;
            opIsDiv  <= 1'b0;
            firstRun <= 1'b0;
        end else begin
            state    <= nextState;
            firstRun <= (state == IDLE) && startAny;
            if ((state == IDLE) && startAny) begin
                // mult has priority when both requests arrive together
                opIsDiv <= ~start_mult;
                latCnt  <= start_mult ? MULT_CNT : DIV_CNT;
            end else if ((state == RUN) && (latCnt != '0)) begin
                latCnt <= latCnt - 1'b1;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (startAny)
                    nextState = RUN;
            end
            RUN: begin
                // abort beats divide-by-zero, which beats normal completion
                if (abortHit)
                    nextState = IDLE;
                else if (opIsDiv && div_by_zero)
                    nextState = EXC;
                else if (latCnt == '0)
                    nextState = WB;
            end
            WB:      nextState = DONE;
            DONE:    nextState = IDLE;
            EXC:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign mult_op      = (state == RUN) && firstRun && !opIsDiv;
    assign div_op       = (state == RUN) && firstRun && opIsDiv;
    assign mult_div_sel = opIsDiv;
    assign hi_lo_write  = (state == WB);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign div_zero_exc = (state == EXC);

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer with LAT=4; each output is traced per cycle into a
// bit vector (bit k = cycle k, cycle k follows edge k-1) and compared to hand-computed patterns.
module tb_mult_div_sequencer;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;
    logic start_mult, start_div, div_by_zero;
`ifdef MULTDIV_ABORT_EN
    logic abort;
    logic [15:0] stimAbort;
`endif
    logic mult_op, div_op, mult_div_sel, hi_lo_write, busy, done, div_zero_exc;

    logic [15:0] stimMult, stimDiv, stimDbz;
    logic [15:0] trMultOp, trDivOp, trSel, trHlw, trBusy, trDone, trExc;

    int testsRun    = 0;
    int testsFailed = 0;

    mult_div_sequencer #(.MULT_LAT(LAT), .DIV_LAT(LAT), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_mult  (start_mult),
        .start_div   (start_div),
        .div_by_zero (div_by_zero),
`ifdef MULTDIV_ABORT_EN
        .abort       (abort),
`endif
        .mult_op     (mult_op),
        .div_op      (div_op),
        .mult_div_sel(mult_div_sel),
        .hi_lo_write (hi_lo_write),
        .busy        (busy),
        .done        (done),
        .div_zero_exc(div_zero_exc)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] allOuts();
        return {9'd0, mult_op, div_op, mult_div_sel, hi_lo_write, busy, done, div_zero_exc};
    endfunction

    task automatic clearStim();
        stimMult = '0;
        stimDiv  = '0;
        stimDbz  = '0;
`ifdef MULTDIV_ABORT_EN
        stimAbort = '0;
`endif
    endtask

    // bit e of each stim vector is the value presented to edge e
    task automatic runTrace(input int n);
        trMultOp = '0; trDivOp = '0; trSel = '0; trHlw = '0;
        trBusy   = '0; trDone  = '0; trExc = '0;
        for (int e = 0; e < n; e++) begin
            start_mult  = stimMult[e];
            start_div   = stimDiv[e];
            div_by_zero = stimDbz[e];
`ifdef MULTDIV_ABORT_EN
            abort = stimAbort[e];
`endif
            @(posedge clk);
            #1;
            trMultOp[e+1] = mult_op;
            trDivOp[e+1]  = div_op;
            trSel[e+1]    = mult_div_sel;
            trHlw[e+1]    = hi_lo_write;
            trBusy[e+1]   = busy;
            trDone[e+1]   = done;
            trExc[e+1]    = div_zero_exc;
        end
        start_mult  = 1'b0;
        start_div   = 1'b0;
        div_by_zero = 1'b0;
`ifdef MULTDIV_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        start_mult  = 1'b0;
        start_div   = 1'b0;
        div_by_zero = 1'b0;
`ifdef MULTDIV_ABORT_EN
        abort = 1'b0;
`endif
        clearStim();
        #8;
        checkEq("reset_outs", allOuts(), 16'h0000);
        #4 reset = 1'b0;

        // 1: plain multiply
        clearStim();
        stimMult = 16'h0001;
        runTrace(8);
        checkEq("t1_mult_op", trMultOp, 16'h0002);
        checkEq("t1_div_op",  trDivOp,  16'h0000);
        checkEq("t1_busy",    trBusy,   16'h007E);
        checkEq("t1_hlw",     trHlw,    16'h0020);
        checkEq("t1_done",    trDone,   16'h0040);
        checkEq("t1_sel",     trSel,    16'h0000);
        checkEq("t1_exc",     trExc,    16'h0000);

        // 2: plain divide; select holds into IDLE afterwards
        clearStim();
        stimDiv = 16'h0001;
        runTrace(8);
        checkEq("t2_div_op",  trDivOp,  16'h0002);
        checkEq("t2_mult_op", trMultOp, 16'h0000);
        checkEq("t2_hlw",     trHlw,    16'h0020);
        checkEq("t2_done",    trDone,   16'h0040);
        checkEq("t2_sel",     trSel,    16'h01FE);
        checkEq("t2_busy",    trBusy,   16'h007E);

        // 3: divide-by-zero at second RUN edge
        clearStim();
        stimDiv = 16'h0001;
        stimDbz = 16'h0004;
        runTrace(8);
        checkEq("t3_exc",  trExc,  16'h0008);
        checkEq("t3_hlw",  trHlw,  16'h0000);
        checkEq("t3_done", trDone, 16'h0000);
        checkEq("t3_busy", trBusy, 16'h000E);

        // 3b: div_by_zero ignored during multiply
        clearStim();
        stimMult = 16'h0001;
        stimDbz  = 16'h001E;
        runTrace(8);
        checkEq("t3b_exc",  trExc,  16'h0000);
        checkEq("t3b_hlw",  trHlw,  16'h0020);
        checkEq("t3b_done", trDone, 16'h0040);

        // 4: simultaneous starts, start while busy, start on DONE->IDLE edge
        clearStim();
        stimMult = 16'h0001;
        stimDiv  = 16'h0045;
        runTrace(10);
        checkEq("t4_mult_op", trMultOp, 16'h0002);
        checkEq("t4_div_op",  trDivOp,  16'h0000);
        checkEq("t4_sel",     trSel,    16'h0000);
        checkEq("t4_busy",    trBusy,   16'h007E);
        checkEq("t4_hlw",     trHlw,    16'h0020);
        checkEq("t4_done",    trDone,   16'h0040);

        // 5: async reset in the middle of a divide, then a clean multiply
        clearStim();
        stimDiv = 16'h0001;
        runTrace(2);
        checkEq("t5_busy_pre", {15'd0, busy},         16'h0001);
        checkEq("t5_sel_pre",  {15'd0, mult_div_sel}, 16'h0001);
        #3 reset = 1'b1;
        #1;
        checkEq("t5_rst_outs", allOuts(), 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        clearStim();
        stimMult = 16'h0001;
        runTrace(8);
        checkEq("t5_mult_op", trMultOp, 16'h0002);
        checkEq("t5_busy",    trBusy,   16'h007E);
        checkEq("t5_hlw",     trHlw,    16'h0020);
        checkEq("t5_done",    trDone,   16'h0040);

`ifdef MULTDIV_ABORT_EN
        // 6: abort at third RUN edge wins over div_by_zero
        clearStim();
        stimDiv   = 16'h0001;
        stimAbort = 16'h0008;
        stimDbz   = 16'h0008;
        runTrace(8);
        checkEq("t6_busy", trBusy, 16'h000E);
        checkEq("t6_exc",  trExc,  16'h0000);
        checkEq("t6_hlw",  trHlw,  16'h0000);
        checkEq("t6_done", trDone, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
